alu_flag_cond_unit: RTL and testbench

ALU_FLAG_COND_UNIT -- requirements
Module: alu_flag_cond_unit

---
 rtl/alu_flag_cond_unit.sv | 219 +++++++++++++++++++++
 tb/tb_alu_flag_cond_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_cond_unit.sv
// Purpose: stores ALU flags, tracks overflow history and evaluates ARM-style condition codes.
// Latency: a request accepted at edge n has its result registered at edge n+1, with eval_done high in the cycle that follows.
// Backpressure: eval_req is dropped while busy; one evaluation per three cycles, no queuing.
module alu_flag_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       Cero,
  input  logic       Negativo,
  input  logic       C_out,
  input  logic       Overflow,
  input  logic       flags_valid,
  input  logic       eval_req,
  input  logic [3:0] cond,
  input  logic       sticky_clr,
  output logic [3:0] flag_reg,
  output logic       busy,
  output logic       eval_done,
  output logic       cond_true,
  output logic       sticky_ovf,
  output logic [3:0] ovf_count
);

  // Condition code encodings
  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam logic [3:0] OVF_CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_flag_reg;
  logic [3:0] r_cond;
  logic [3:0] r_ovf_count;
  logic       r_sticky_ovf;
  logic       r_cond_true;

  logic       w_ovf_inc;
  logic       w_accept;
  logic       w_busy;
  logic       w_eval_done;
  logic       w_eval_cycle;
  logic       w_cond_result;

  // Individual stored flags, bit order {V,C,N,Z}
  logic       w_flag_z;
  logic       w_flag_n;
  logic       w_flag_c;
  logic       w_flag_v;
  logic       w_n_eq_v;

  assign w_flag_z = r_flag_reg[0];
  assign w_flag_n = r_flag_reg[1];
  assign w_flag_c = r_flag_reg[2];
  assign w_flag_v = r_flag_reg[3];
  assign w_n_eq_v = (w_flag_n == w_flag_v);

  // ---------------------------------------------------------------
  // Flag storage and overflow history (independent of the FSM)
  // ---------------------------------------------------------------

  // Capture the four datapath flags whenever the strobe is high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag_reg <= 4'b0000;
    end else if (flags_valid) begin
      r_flag_reg <= {Overflow, C_out, Negativo, Cero};
    end
  end

  // An overflow only counts when it arrives with a capture strobe
  always_comb begin
    w_ovf_inc = flags_valid & Overflow;
  end

  // Sticky overflow: a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky_ovf <= 1'b0;
    end else if (w_ovf_inc) begin
      r_sticky_ovf <= 1'b1;
    end else if (sticky_clr) begin
      r_sticky_ovf <= 1'b0;
    end
  end

  // Saturating overflow counter; clear plus increment restarts at one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_count <= 4'd0;
    end else if (sticky_clr) begin
      r_ovf_count <= w_ovf_inc ? 4'd1 : 4'd0;
    end else if (w_ovf_inc && (r_ovf_count != OVF_CNT_MAX)) begin
      r_ovf_count <= r_ovf_count + 4'd1;
    end
  end

  // ---------------------------------------------------------------
  // Evaluation FSM: IDLE -> EVAL -> DONE -> IDLE
  // ---------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; requests outside IDLE are simply dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = eval_req ? S_EVAL : S_IDLE;
      S_EVAL:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs and strobes
  always_comb begin
    w_busy       = 1'b0;
    w_eval_done  = 1'b0;
    w_eval_cycle = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = eval_req;
      end
      S_EVAL: begin
        w_busy       = 1'b1;
        w_eval_cycle = 1'b1;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_eval_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Hold the condition code of the accepted request for the EVAL cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond <= 4'd0;
    end else if (w_accept) begin
      r_cond <= cond;
    end
  end

  // ---------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------

  // Decode the latched condition against the flags held this cycle
  always_comb begin
    w_cond_result = 1'b0;
    case (r_cond)
      CC_EQ:   w_cond_result = w_flag_z;
      CC_NE:   w_cond_result = ~w_flag_z;
      CC_CS:   w_cond_result = w_flag_c;
      CC_CC:   w_cond_result = ~w_flag_c;
      CC_MI:   w_cond_result = w_flag_n;
      CC_PL:   w_cond_result = ~w_flag_n;
      CC_VS:   w_cond_result = w_flag_v;
      CC_VC:   w_cond_result = ~w_flag_v;
      CC_HI:   w_cond_result = w_flag_c & ~w_flag_z;
      CC_LS:   w_cond_result = ~w_flag_c | w_flag_z;
      CC_GE:   w_cond_result = w_n_eq_v;
      CC_LT:   w_cond_result = ~w_n_eq_v;
      CC_GT:   w_cond_result = ~w_flag_z & w_n_eq_v;
      CC_LE:   w_cond_result = w_flag_z | ~w_n_eq_v;
      CC_AL:   w_cond_result = 1'b1;
      CC_NV:   w_cond_result = 1'b0;
      default: w_cond_result = 1'b0;
    endcase
  end

  // Register the result at the EVAL->DONE edge; held until the next evaluation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond_true <= 1'b0;
    end else if (w_eval_cycle) begin
      r_cond_true <= w_cond_result;
    end
  end

  assign flag_reg   = r_flag_reg;
  assign busy       = w_busy;
  assign eval_done  = w_eval_done;
  assign cond_true  = r_cond_true;
  assign sticky_ovf = r_sticky_ovf;
  assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_alu_flag_cond_unit.sv
// Bench for alu_flag_cond_unit: literal vector table, directed corner sequences,
// exhaustive cond x flags sweep and randomized traffic against a cycle-level model.
module tb_alu_flag_cond_unit;

  logic       clk;
  logic       reset;
  logic       Cero, Negativo, C_out, Overflow;
  logic       flags_valid;
  logic       eval_req;
  logic [3:0] cond;
  logic       sticky_clr;
  logic [3:0] flag_reg;
  logic       busy;
  logic       eval_done;
  logic       cond_true;
  logic       sticky_ovf;
  logic [3:0] ovf_count;

  int n_checks = 0;
  int n_errors = 0;

  alu_flag_cond_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Cero        (Cero),
    .Negativo    (Negativo),
    .C_out       (C_out),
    .Overflow    (Overflow),
    .flags_valid (flags_valid),
    .eval_req    (eval_req),
    .cond        (cond),
    .sticky_clr  (sticky_clr),
    .flag_reg    (flag_reg),
    .busy        (busy),
    .eval_done   (eval_done),
    .cond_true   (cond_true),
    .sticky_ovf  (sticky_ovf),
    .ovf_count   (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Flags are {V,C,N,Z}. Conditions come in pairs: odd codes are the
  // negation of the even code below them.
  function automatic bit cond_ref(input int c, input logic [3:0] f);
    bit v, cy, n, z, base;
    v = f[3]; cy = f[2]; n = f[1]; z = f[0];
    case (c / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c % 2 == 1) ? !base : base;
  endfunction

  logic [3:0] m_flags;
  bit         m_sticky;
  int         m_cnt;
  bit         m_ct;
  int         m_age;   // cycles since the active request was accepted, -1 when none
  int         m_cond;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare every output a little after the edge.
  task automatic tick();
    bit inc;
    @(posedge clk);
    if (reset) begin
      m_flags = 4'b0; m_sticky = 0; m_cnt = 0; m_ct = 0; m_age = -1; m_cond = 0;
    end else begin
      inc = flags_valid && Overflow;
      if (m_age == 0) m_ct = cond_ref(m_cond, m_flags);
      if (m_age >= 0) begin
        m_age++;
        if (m_age > 1) m_age = -1;
      end else if (eval_req) begin
        m_age = 0;
        m_cond = int'(cond);
      end
      if (flags_valid) m_flags = {Overflow, C_out, Negativo, Cero};
      if (inc) m_sticky = 1;
      else if (sticky_clr) m_sticky = 0;
      if (sticky_clr) m_cnt = inc ? 1 : 0;
      else if (inc && m_cnt < 15) m_cnt++;
    end
    #1;
    check("model", {20'd0, flag_reg, busy, eval_done, cond_true, sticky_ovf, ovf_count},
          {20'd0, m_flags, (m_age == 0 || m_age == 1), (m_age == 1), m_ct, m_sticky, 4'(m_cnt)});
  endtask

  task automatic idle_in();
    flags_valid = 0; eval_req = 0; sticky_clr = 0; cond = 4'd0;
    {Overflow, C_out, Negativo, Cero} = 4'b0000;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flags_valid = 1;
    {Overflow, C_out, Negativo, Cero} = f;
  endtask

  // ---------------- literal vector table ----------------
  typedef struct {
    logic [3:0] flags;   // {V,C,N,Z}
    logic [3:0] cc;
    logic       exp_true;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{4'b0001, 4'd0,  1'b1};
    vecs[1]  = '{4'b0000, 4'd0,  1'b0};
    vecs[2]  = '{4'b0000, 4'd1,  1'b1};
    vecs[3]  = '{4'b0100, 4'd2,  1'b1};
    vecs[4]  = '{4'b0100, 4'd3,  1'b0};
    vecs[5]  = '{4'b0010, 4'd4,  1'b1};
    vecs[6]  = '{4'b0010, 4'd5,  1'b0};
    vecs[7]  = '{4'b1000, 4'd6,  1'b1};
    vecs[8]  = '{4'b0000, 4'd7,  1'b1};
    vecs[9]  = '{4'b0100, 4'd8,  1'b1};
    vecs[10] = '{4'b0101, 4'd8,  1'b0};
    vecs[11] = '{4'b0101, 4'd9,  1'b1};
    vecs[12] = '{4'b1010, 4'd10, 1'b1};
    vecs[13] = '{4'b0010, 4'd11, 1'b1};
    vecs[14] = '{4'b1000, 4'd12, 1'b0};
    vecs[15] = '{4'b0000, 4'd12, 1'b1};
    vecs[16] = '{4'b0001, 4'd13, 1'b1};
    vecs[17] = '{4'b1111, 4'd14, 1'b1};
    vecs[18] = '{4'b1111, 4'd15, 1'b0};

    m_age = -1; m_flags = 0; m_sticky = 0; m_cnt = 0; m_ct = 0; m_cond = 0;
    idle_in();
    reset = 1;
    tick(); tick();
    check("reset_state", {flag_reg, busy, eval_done, cond_true, sticky_ovf, ovf_count}, 12'h000);
    reset = 0;
    tick();

    // Basic EQ evaluation and timing
    set_flags(4'b0001); tick();
    idle_in(); eval_req = 1; cond = 4'd0; tick();
    check("eq_busy_eval", {busy, eval_done}, 2'b10);
    idle_in(); tick();
    check("eq_done", {busy, eval_done, cond_true}, 3'b111);
    tick();
    check("eq_idle", {busy, eval_done, cond_true}, 3'b001);

    // Capture in the request cycle is seen by the evaluation
    set_flags(4'b1000); eval_req = 1; cond = 4'd10; tick();
    idle_in(); tick();
    check("ge_same_cycle", {eval_done, cond_true}, 2'b10);
    tick();

    // Capture during EVAL is not seen; requests in EVAL/DONE are dropped
    set_flags(4'b0000); tick();
    idle_in(); eval_req = 1; cond = 4'd1; tick();
    set_flags(4'b0001); eval_req = 1; cond = 4'd0; tick();
    check("ne_ignores_late_flags", {flag_reg, eval_done, cond_true}, 6'b0001_11);
    idle_in(); eval_req = 1; tick();
    check("no_extra_done_1", {busy, eval_done}, 2'b00);
    idle_in(); tick();
    check("no_extra_done_2", {busy, eval_done}, 2'b00);

    // Overflow counter saturation and clear-with-increment
    sticky_clr = 1; tick(); idle_in();
    for (int i = 0; i < 17; i++) begin
      set_flags(4'b1000); tick();
    end
    check("ovf_saturate", {sticky_ovf, ovf_count}, 5'b1_1111);
    set_flags(4'b1000); sticky_clr = 1; tick();
    check("clr_with_ovf", {sticky_ovf, ovf_count}, 5'b1_0001);
    idle_in(); sticky_clr = 1; tick();
    check("clr_alone", {sticky_ovf, ovf_count}, 5'b0_0000);
    idle_in(); tick();

    // Reset in EVAL aborts the evaluation
    set_flags(4'b1111); eval_req = 1; cond = 4'd14; tick();
    idle_in(); tick(); tick();
    check("al_before_reset", {cond_true, sticky_ovf}, 2'b11);
    eval_req = 1; cond = 4'd15; tick();
    check("in_eval", busy, 1'b1);
    idle_in(); reset = 1; tick();
    check("reset_in_eval", {flag_reg, busy, eval_done, cond_true, sticky_ovf, ovf_count}, 12'h000);
    reset = 0; tick();
    check("no_done_after_abort", {busy, eval_done}, 2'b00);

    // Literal vector table
    foreach (vecs[i]) begin
      set_flags(vecs[i].flags); eval_req = 1; cond = vecs[i].cc; tick();
      idle_in(); tick();
      check($sformatf("vec%0d", i), {eval_done, cond_true}, {1'b1, vecs[i].exp_true});
      tick(); tick();
    end

    // Exhaustive sweep against the model's rule
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        set_flags(4'(f)); eval_req = 1; cond = 4'(c); tick();
        idle_in(); tick();
        check($sformatf("sweep_f%0d_c%0d", f, c), cond_true, cond_ref(c, 4'(f)));
        tick(); tick();
      end
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) < 2);
      flags_valid = $urandom_range(0, 1);
      {Overflow, C_out, Negativo, Cero} = 4'($urandom_range(0, 15));
      eval_req    = $urandom_range(0, 1);
      cond        = 4'($urandom_range(0, 15));
      sticky_clr  = ($urandom_range(0, 99) < 3);
      tick();
    end
    idle_in(); reset = 0; tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
